chamber_pump_ctrl: RTL and testbench
====================================

// Module: chamber_pump_ctrl
// PURPOSE
//  Downstream consumer of the airlock evacuation request. Models chamber pressure
//  as a level counter and drives the pump and vent.
//  Returns the Evacuated and Pressurized status flags to the upstream door/evacuation FSMs.
//  Trips to FAULT if a door opens while the pump or vent is active.
// PARAMETERS
//  PW        4  width of the pressure level counter
//  P_MAX     7  ambient (full) pressure level; constraint 1 <= P_MAX < 2**PW
//  TICK_DIV  4  clock cycles per one-step level change; constraint TICK_DIV >= 1
// PORTS
//  Clock        in   1   system clock, all state updates on the rising edge
//  Reset        in   1   synchronous, active-high
//  Evacuation   in   1   evacuate request from the upstream evacuation FSM
//  Pressurize   in   1   pressurize request
//  InnerClosed  in   1   1 = inner door closed
//  OuterClosed  in   1   1 = outer door closed
//  FaultClear   in   1   operator acknowledge; leaves FAULT
//  Level        out  PW  current chamber pressure level (registered)
//  Evacuated    out  1   1 while state == EVACUATED
//  Pressurized  out  1   1 while state == PRESSURIZED
//  Pumping      out  1   1 while state == EVACUATING
//  Venting      out  1   1 while state == PRESSURIZING
//  Fault        out  1   1 while state == FAULT
// BEHAVIOUR
//  - Reset is synchronous, active-high, on Clock.
//    Reset state: state = PRESSURIZED, Level = P_MAX, tick = 0.
//    Reset outputs: Pressurized = 1, all other flags = 0.
//    Reset applied mid-operation restores these values at the next edge.
//  - Outputs are decoded from registered state/Level only; no combinational path from any input.
//  - tick is a 0..TICK_DIV-1 counter; it clears on every state change.
//  - PRESSURIZED:
//    - Evacuation && InnerClosed && OuterClosed -> EVACUATING.
//    - Pressurize is ignored.
//    - Evacuation takes priority if Evacuation and Pressurize are high together.
//  - EVACUATING:
//    - Priority 1: either door open -> FAULT. Level holds; FAULT wins even on a step cycle.
//    - Priority 2: !Evacuation -> PRESSURIZING (abort, refill).
//    - Otherwise tick++. When tick == TICK_DIV-1: tick = 0, Level--.
//    - If Level == 1 at that step, Level -> 0 and state -> EVACUATED on the same edge.
//  - EVACUATED:
//    - Level stays 0.
//    - Door opening here is legal (no fault).
//    - Pressurize && both doors closed -> PRESSURIZING; Evacuation is ignored.
//  - PRESSURIZING:
//    - Door open -> FAULT.
//    - Otherwise count tick as in EVACUATING, with Level++ on each step.
//    - Level reaching P_MAX -> PRESSURIZED on the same edge.
//    - Evacuation and Pressurize are ignored until complete.
//  - FAULT:
//    - Level frozen; Pumping = Venting = 0.
//    - FaultClear && both doors closed -> PRESSURIZED if Level == P_MAX, else PRESSURIZING.
//    - FaultClear with any door open is ignored.
//  - Latency, full evacuation: request sampled at edge N; EVACUATING from N+1.
//    Evacuated = 1 after the edge at N + P_MAX*TICK_DIV.
//    With defaults: 28 edges after the sampling edge.
//  - Pressurization from 0 takes the same P_MAX*TICK_DIV cycles in PRESSURIZING.
//  - Level never wraps: saturates at 0 and P_MAX by construction of the transitions.
// TESTING
//  1. Reset, doors closed, Evacuation = 1 held ->
//     Pumping from the next cycle; Level steps 7..0 every 4 cycles; Evacuated = 1, Pumping = 0 after 28 cycles.
//  2. From EVACUATED, Pressurize = 1, doors closed ->
//     Venting = 1; Level 0..7 in 28 cycles; Pressurized = 1.
//  3. EVACUATING at Level = 4, OuterClosed -> 0 ->
//     next cycle Fault = 1, Level = 4 frozen.
//     FaultClear with door open: no change.
//     Close door + FaultClear: PRESSURIZING, reaches 7 after 12 cycles.
//  4. EVACUATING at Level = 5, Evacuation drops -> PRESSURIZING; Level returns to 7.
//  5. Evacuation and Pressurize both high in PRESSURIZED -> EVACUATING.
//     In EVACUATED, OuterClosed = 0: no fault, Evacuated stays 1.
//  6. Reset asserted mid-PRESSURIZING at Level = 3 ->
//     next edge Level = 7, Pressurized = 1, all other flags = 0.

Source files
------------

// File: rtl/chamber_pump_ctrl_if.sv
// rtl/chamber_pump_ctrl_if.sv - request/door inputs and status outputs of the chamber pump controller
//
// Purpose: bundles the evacuation/pressurize requests, door sensors, operator
//          fault acknowledge and the returned level/status flags.
// Signals:
//   Evacuation, Pressurize    requests from the upstream evacuation FSM
//   InnerClosed, OuterClosed  1 = door closed
//   FaultClear                operator acknowledge
//   Level [PW]                chamber pressure level
//   Evacuated, Pressurized, Pumping, Venting, Fault   state flags
// Modports: master = upstream side, slave = pump controller.

interface chamber_pump_ctrl_if #(
    parameter int PW = 4
);
    logic          Evacuation;
    logic          Pressurize;
    logic          InnerClosed;
    logic          OuterClosed;
    logic          FaultClear;
    logic [PW-1:0] Level;
    logic          Evacuated;
    logic          Pressurized;
    logic          Pumping;
    logic          Venting;
    logic          Fault;

    modport master (
        output Evacuation, Pressurize, InnerClosed, OuterClosed, FaultClear,
        input  Level, Evacuated, Pressurized, Pumping, Venting, Fault
    );

    modport slave (
        input  Evacuation, Pressurize, InnerClosed, OuterClosed, FaultClear,
        output Level, Evacuated, Pressurized, Pumping, Venting, Fault
    );
endinterface

// File: rtl/chamber_pump_ctrl.sv
// rtl/chamber_pump_ctrl.sv - airlock chamber pressure model driving pump and vent
//
// Purpose: models chamber pressure as a level counter that moves one step every
//          TICK_DIV cycles while pumping or venting, reports Evacuated /
//          Pressurized status upstream and trips to FAULT if a door opens while
//          the pump or vent is active.
// Ports:
//   Clock   in  system clock, rising edge
//   Reset   in  synchronous, active-high
//   bus     slave modport of chamber_pump_ctrl_if (requests, doors, FaultClear
//           in; Level and state flags out, all decoded from registers)

module chamber_pump_ctrl #(
    parameter int PW       = 4,
    parameter int P_MAX    = 7,
    parameter int TICK_DIV = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    chamber_pump_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_PRESSURIZED  = 3'd0,
        S_EVACUATING   = 3'd1,
        S_EVACUATED    = 3'd2,
        S_PRESSURIZING = 3'd3,
        S_FAULT        = 3'd4
    } state_t;

    // A one-bit tick is kept even for TICK_DIV == 1 so the counter always exists.
    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] LEVEL_MAX = PW'(P_MAX);
    localparam logic [PW-1:0] LEVEL_ONE = PW'(1);

    state_t        r_state;
    logic [PW-1:0] r_level;
    logic [TW-1:0] r_tick;

    state_t        w_next_state;
    logic [PW-1:0] w_next_level;
    logic [TW-1:0] w_next_tick;
    logic          w_doors_closed;
    logic          w_step;

    assign w_doors_closed = bus.InnerClosed & bus.OuterClosed;
    assign w_step         = (r_tick == TICK_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_PRESSURIZED;
            r_level <= LEVEL_MAX;
            r_tick  <= '0;
        end else begin
            r_state <= w_next_state;
            r_level <= w_next_level;
            r_tick  <= w_next_tick;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        w_next_tick  = r_tick;
        case (r_state)
            S_PRESSURIZED: begin
                w_next_tick = '0;
                if (bus.Evacuation && w_doors_closed)
                    w_next_state = S_EVACUATING;
            end
            S_EVACUATING: begin
                // Door check outranks everything, including a step on this edge.
                if (!w_doors_closed) begin
                    w_next_state = S_FAULT;
                    w_next_tick  = '0;
                end else if (!bus.Evacuation) begin
                    w_next_state = S_PRESSURIZING;
                    w_next_tick  = '0;
                end else if (w_step) begin
                    w_next_tick = '0;
                    if (r_level <= LEVEL_ONE) begin
                        w_next_level = '0;
                        w_next_state = S_EVACUATED;
                    end else begin
                        w_next_level = r_level - LEVEL_ONE;
                    end
                end else begin
                    w_next_tick = r_tick + TW'(1);
                end
            end
            S_EVACUATED: begin
                // Doors may open freely here; the chamber is already at vacuum.
                w_next_tick  = '0;
                w_next_level = '0;
                if (bus.Pressurize && w_doors_closed)
                    w_next_state = S_PRESSURIZING;
            end
            S_PRESSURIZING: begin
                if (!w_doors_closed) begin
                    w_next_state = S_FAULT;
                    w_next_tick  = '0;
                end else if (w_step) begin
                    w_next_tick = '0;
                    // Saturating: an abort taken before the first pump step
                    // enters here already at full level.
                    if (r_level >= LEVEL_MAX - LEVEL_ONE) begin
                        w_next_level = LEVEL_MAX;
                        w_next_state = S_PRESSURIZED;
                    end else begin
                        w_next_level = r_level + LEVEL_ONE;
                    end
                end else begin
                    w_next_tick = r_tick + TW'(1);
                end
            end
            S_FAULT: begin
                w_next_tick = '0;
                if (bus.FaultClear && w_doors_closed)
                    w_next_state = (r_level == LEVEL_MAX) ? S_PRESSURIZED : S_PRESSURIZING;
            end
            default: begin
                w_next_state = S_PRESSURIZED;
                w_next_level = LEVEL_MAX;
                w_next_tick  = '0;
            end
        endcase
    end

    logic w_evacuated;
    logic w_pressurized;
    logic w_pumping;
    logic w_venting;
    logic w_fault;

    always_comb begin
        w_evacuated   = 1'b0;
        w_pressurized = 1'b0;
        w_pumping     = 1'b0;
        w_venting     = 1'b0;
        w_fault       = 1'b0;
        case (r_state)
            S_PRESSURIZED:  w_pressurized = 1'b1;
            S_EVACUATING:   w_pumping     = 1'b1;
            S_EVACUATED:    w_evacuated   = 1'b1;
            S_PRESSURIZING: w_venting     = 1'b1;
            S_FAULT:        w_fault       = 1'b1;
            default:        w_pressurized = 1'b0;
        endcase
    end

    assign bus.Level       = r_level;
    assign bus.Evacuated   = w_evacuated;
    assign bus.Pressurized = w_pressurized;
    assign bus.Pumping     = w_pumping;
    assign bus.Venting     = w_venting;
    assign bus.Fault       = w_fault;

endmodule

// File: tb/tb_chamber_pump_ctrl.sv
// tb/tb_chamber_pump_ctrl.sv - self-checking bench for chamber_pump_ctrl

module tb_chamber_pump_ctrl;

    localparam int PW       = 4;
    localparam int P_MAX    = 7;
    localparam int TICK_DIV = 4;
    localparam int FULL     = P_MAX * TICK_DIV;

    // Flag vector order: {Evacuated, Pressurized, Pumping, Venting, Fault}
    localparam logic [4:0] F_EVACD = 5'b10000;
    localparam logic [4:0] F_PRESS = 5'b01000;
    localparam logic [4:0] F_PUMP  = 5'b00100;
    localparam logic [4:0] F_VENT  = 5'b00010;
    localparam logic [4:0] F_FAULT = 5'b00001;

    localparam int ST_PRESS = 0;
    localparam int ST_EVING = 1;
    localparam int ST_EVACD = 2;
    localparam int ST_PRING = 3;
    localparam int ST_FAULT = 4;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    chamber_pump_ctrl_if #(.PW(PW)) bus ();

    chamber_pump_ctrl #(
        .PW       (PW),
        .P_MAX    (P_MAX),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    function automatic logic [4:0] act_flags();
        return {bus.Evacuated, bus.Pressurized, bus.Pumping, bus.Venting, bus.Fault};
    endfunction

    function automatic logic [4:0] state_flags(input int st);
        case (st)
            ST_PRESS: return F_PRESS;
            ST_EVING: return F_PUMP;
            ST_EVACD: return F_EVACD;
            ST_PRING: return F_VENT;
            default:  return F_FAULT;
        endcase
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Evacuation  = 1'b0;
        bus.Pressurize  = 1'b0;
        bus.InnerClosed = 1'b1;
        bus.OuterClosed = 1'b1;
        bus.FaultClear  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.Evacuation = 1'b1;
        Reset = 1'b1;
        step();
        checks++;
        if (bus.Level !== PW'(P_MAX) || act_flags() !== F_PRESS) begin
            errors++;
            $display("FAIL reset level=%0d flags=%b expected level=%0d flags=%b",
                     bus.Level, act_flags(), P_MAX, F_PRESS);
        end
        Reset = 1'b0;
        bus.Evacuation = 1'b0;
        step();
        checks++;
        if (bus.Level !== PW'(P_MAX) || act_flags() !== F_PRESS) begin
            errors++;
            $display("FAIL reset_idle level=%0d flags=%b expected level=%0d flags=%b",
                     bus.Level, act_flags(), P_MAX, F_PRESS);
        end
    endtask

    task automatic test_evacuate();
        logic [PW-1:0] exp_lvl;
        logic [4:0]    exp_fl;
        do_reset();
        bus.Evacuation = 1'b1;
        step();
        checks++;
        if (bus.Level !== PW'(P_MAX) || act_flags() !== F_PUMP) begin
            errors++;
            $display("FAIL evac_start level=%0d flags=%b expected level=%0d flags=%b",
                     bus.Level, act_flags(), P_MAX, F_PUMP);
        end
        for (int e = 1; e <= FULL; e++) begin
            step();
            exp_lvl = PW'(P_MAX - e / TICK_DIV);
            exp_fl  = (e == FULL) ? F_EVACD : F_PUMP;
            checks++;
            if (bus.Level !== exp_lvl || act_flags() !== exp_fl) begin
                errors++;
                $display("FAIL evacuate e=%0d level=%0d flags=%b expected level=%0d flags=%b",
                         e, bus.Level, act_flags(), exp_lvl, exp_fl);
            end
        end
        bus.Evacuation = 1'b0;
    endtask

    task automatic test_pressurize();
        logic [PW-1:0] exp_lvl;
        logic [4:0]    exp_fl;
        bus.Pressurize = 1'b1;
        step();
        checks++;
        if (bus.Level !== '0 || act_flags() !== F_VENT) begin
            errors++;
            $display("FAIL press_start level=%0d flags=%b expected level=0 flags=%b",
                     bus.Level, act_flags(), F_VENT);
        end
        for (int e = 1; e <= FULL; e++) begin
            step();
            exp_lvl = PW'(e / TICK_DIV);
            exp_fl  = (e == FULL) ? F_PRESS : F_VENT;
            checks++;
            if (bus.Level !== exp_lvl || act_flags() !== exp_fl) begin
                errors++;
                $display("FAIL pressurize e=%0d level=%0d flags=%b expected level=%0d flags=%b",
                         e, bus.Level, act_flags(), exp_lvl, exp_fl);
            end
        end
        bus.Pressurize = 1'b0;
    endtask

    task automatic test_fault();
        logic [PW-1:0] exp_lvl;
        logic [4:0]    exp_fl;
        do_reset();
        bus.Evacuation = 1'b1;
        step();
        for (int e = 1; e <= 3 * TICK_DIV; e++) step();
        checks++;
        if (bus.Level !== PW'(4) || act_flags() !== F_PUMP) begin
            errors++;
            $display("FAIL fault_pre level=%0d flags=%b expected level=4 flags=%b",
                     bus.Level, act_flags(), F_PUMP);
        end
        bus.OuterClosed = 1'b0;
        step();
        checks++;
        if (bus.Level !== PW'(4) || act_flags() !== F_FAULT) begin
            errors++;
            $display("FAIL fault_trip level=%0d flags=%b expected level=4 flags=%b",
                     bus.Level, act_flags(), F_FAULT);
        end
        bus.FaultClear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.Level !== PW'(4) || act_flags() !== F_FAULT) begin
                errors++;
                $display("FAIL fault_clear_door_open level=%0d flags=%b expected level=4 flags=%b",
                         bus.Level, act_flags(), F_FAULT);
            end
        end
        bus.OuterClosed = 1'b1;
        step();
        bus.FaultClear = 1'b0;
        checks++;
        if (bus.Level !== PW'(4) || act_flags() !== F_VENT) begin
            errors++;
            $display("FAIL fault_clear level=%0d flags=%b expected level=4 flags=%b",
                     bus.Level, act_flags(), F_VENT);
        end
        for (int e = 1; e <= 3 * TICK_DIV; e++) begin
            step();
            exp_lvl = PW'(4 + e / TICK_DIV);
            exp_fl  = (e == 3 * TICK_DIV) ? F_PRESS : F_VENT;
            checks++;
            if (bus.Level !== exp_lvl || act_flags() !== exp_fl) begin
                errors++;
                $display("FAIL fault_refill e=%0d level=%0d flags=%b expected level=%0d flags=%b",
                         e, bus.Level, act_flags(), exp_lvl, exp_fl);
            end
        end
        bus.Evacuation = 1'b0;
    endtask

    task automatic test_abort();
        logic [PW-1:0] exp_lvl;
        logic [4:0]    exp_fl;
        do_reset();
        bus.Evacuation = 1'b1;
        step();
        for (int e = 1; e <= 2 * TICK_DIV; e++) step();
        bus.Evacuation = 1'b0;
        step();
        checks++;
        if (bus.Level !== PW'(5) || act_flags() !== F_VENT) begin
            errors++;
            $display("FAIL abort level=%0d flags=%b expected level=5 flags=%b",
                     bus.Level, act_flags(), F_VENT);
        end
        for (int e = 1; e <= 2 * TICK_DIV; e++) begin
            step();
            exp_lvl = PW'(5 + e / TICK_DIV);
            exp_fl  = (e == 2 * TICK_DIV) ? F_PRESS : F_VENT;
            checks++;
            if (bus.Level !== exp_lvl || act_flags() !== exp_fl) begin
                errors++;
                $display("FAIL abort_refill e=%0d level=%0d flags=%b expected level=%0d flags=%b",
                         e, bus.Level, act_flags(), exp_lvl, exp_fl);
            end
        end
    endtask

    task automatic test_priority_and_door_legal();
        do_reset();
        bus.Evacuation = 1'b1;
        bus.Pressurize = 1'b1;
        step();
        checks++;
        if (act_flags() !== F_PUMP) begin
            errors++;
            $display("FAIL both_req flags=%b expected flags=%b", act_flags(), F_PUMP);
        end
        bus.Pressurize = 1'b0;
        for (int e = 1; e <= FULL; e++) step();
        checks++;
        if (bus.Level !== '0 || act_flags() !== F_EVACD) begin
            errors++;
            $display("FAIL both_req_done level=%0d flags=%b expected level=0 flags=%b",
                     bus.Level, act_flags(), F_EVACD);
        end
        bus.OuterClosed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.Pressurize = (i >= 3);
            step();
            checks++;
            if (bus.Level !== '0 || act_flags() !== F_EVACD) begin
                errors++;
                $display("FAIL evacd_door_open i=%0d level=%0d flags=%b expected level=0 flags=%b",
                         i, bus.Level, act_flags(), F_EVACD);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.Evacuation = 1'b1;
        step();
        for (int e = 1; e <= FULL; e++) step();
        bus.Evacuation = 1'b0;
        bus.Pressurize = 1'b1;
        step();
        for (int e = 1; e <= 3 * TICK_DIV; e++) step();
        checks++;
        if (bus.Level !== PW'(3) || act_flags() !== F_VENT) begin
            errors++;
            $display("FAIL reset_mid_pre level=%0d flags=%b expected level=3 flags=%b",
                     bus.Level, act_flags(), F_VENT);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (bus.Level !== PW'(P_MAX) || act_flags() !== F_PRESS) begin
            errors++;
            $display("FAIL reset_mid level=%0d flags=%b expected level=%0d flags=%b",
                     bus.Level, act_flags(), P_MAX, F_PRESS);
        end
        idle_inputs();
    endtask

    // Reference model: chamber state name, pressure level and cycles spent on
    // the current pressure step.
    int m_state;
    int m_level;
    int m_cycles;

    task automatic model_edge(input bit rst, input bit ev, input bit pr,
                              input bit closed, input bit fc);
        if (rst) begin
            m_state = ST_PRESS; m_level = P_MAX; m_cycles = 0;
            return;
        end
        case (m_state)
            ST_PRESS: if (ev && closed) begin m_state = ST_EVING; m_cycles = 0; end
            ST_EVING: begin
                if (!closed)   begin m_state = ST_FAULT; m_cycles = 0; end
                else if (!ev)  begin m_state = ST_PRING; m_cycles = 0; end
                else begin
                    m_cycles++;
                    if (m_cycles == TICK_DIV) begin
                        m_cycles = 0;
                        m_level  = (m_level > 0) ? m_level - 1 : 0;
                        if (m_level == 0) m_state = ST_EVACD;
                    end
                end
            end
            ST_EVACD: if (pr && closed) begin m_state = ST_PRING; m_cycles = 0; end
            ST_PRING: begin
                if (!closed) begin m_state = ST_FAULT; m_cycles = 0; end
                else begin
                    m_cycles++;
                    if (m_cycles == TICK_DIV) begin
                        m_cycles = 0;
                        m_level  = (m_level < P_MAX) ? m_level + 1 : P_MAX;
                        if (m_level == P_MAX) m_state = ST_PRESS;
                    end
                end
            end
            default: if (fc && closed) begin
                m_state  = (m_level == P_MAX) ? ST_PRESS : ST_PRING;
                m_cycles = 0;
            end
        endcase
    endtask

    task automatic test_random();
        bit rst;
        do_reset();
        m_state = ST_PRESS; m_level = P_MAX; m_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) bus.Evacuation = ~bus.Evacuation;
            if ($urandom_range(0, 29) == 0) bus.Pressurize = ~bus.Pressurize;
            if (bus.InnerClosed) bus.InnerClosed = ($urandom_range(0, 79) != 0);
            else                 bus.InnerClosed = ($urandom_range(0, 3) == 0);
            if (bus.OuterClosed) bus.OuterClosed = ($urandom_range(0, 79) != 0);
            else                 bus.OuterClosed = ($urandom_range(0, 3) == 0);
            bus.FaultClear = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            Reset = rst;
            model_edge(rst, bus.Evacuation, bus.Pressurize,
                       bus.InnerClosed && bus.OuterClosed, bus.FaultClear);
            step();
            checks++;
            if (bus.Level !== PW'(m_level) || act_flags() !== state_flags(m_state)) begin
                errors++;
                $display("FAIL random c=%0d level=%0d flags=%b expected level=%0d flags=%b",
                         c, bus.Level, act_flags(), m_level, state_flags(m_state));
            end
        end
        Reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        step();
        test_reset();
        test_evacuate();
        test_pressurize();
        test_fault();
        test_abort();
        test_priority_and_door_legal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
